// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, oversampling constants and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK = 7;
  function automatic int tick_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversampling tick generator, phase-restartable through iCLR
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115200
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iCLR,
  output logic oTICK
);
  localparam int DIV = tick_div(CLK_HZ, BAUD);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign oTICK = cnt == W'(DIV - 1);
  always_ff @(posedge iCLK)
    if (!iRST_N || iCLR || oTICK) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 16x-oversampled serial receiver with valid/read holding register
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115200
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRXD,
  input  logic       iREAD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oOVERRUN,
  output logic       oBUSY
);
  uart_rx_state_t state, next_state;
  logic rx_meta, rxs, tick, mid, shift, stop_hit, accept;
  logic [3:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  always_ff @(posedge iCLK)
    if (!iRST_N) {rx_meta, rxs} <= 2'b11;
    else {rx_meta, rxs} <= {iRXD, rx_meta};
  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_tick (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iCLR  (state == IDLE),
    .oTICK (tick)
  );
  always_ff @(posedge iCLK)
    if (!iRST_N) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!rxs) next_state = START;
      START:     if (mid) next_state = rxs ? IDLE : DATA;
      DATA:      if (mid && bit_idx == 3'd7) next_state = STOP;
      STOP:      if (mid) next_state = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end
  always_comb begin
    mid = tick && cnt == (state == START ? 4'(MID_TICK) : 4'(OVERSAMPLE - 1));
    shift = state == DATA && mid;
    stop_hit = state == STOP && mid;
    accept = stop_hit && rxs;
    oBUSY = state != IDLE;
  end
  always_ff @(posedge iCLK)
    if (!iRST_N || state == IDLE) begin
      cnt <= '0;
      bit_idx <= '0;
      shreg <= iRST_N ? shreg : '0;
    end else begin
      cnt <= tick ? (mid ? '0 : cnt + 1'b1) : cnt;
      bit_idx <= shift ? bit_idx + 1'b1 : bit_idx;
      shreg <= shift ? {rxs, shreg[7:1]} : shreg;
    end
  // An accept that coincides with iREAD replaces the pending byte instead of overrunning.
  always_ff @(posedge iCLK)
    if (!iRST_N) begin
      oDATA <= '0;
      oVALID <= 1'b0;
      oOVERRUN <= 1'b0;
      oFRAME_ERR <= 1'b0;
    end else begin
      oFRAME_ERR <= stop_hit && !rxs;
      if (accept && (!oVALID || iREAD)) begin
        oDATA <= shreg;
        oVALID <= 1'b1;
        oOVERRUN <= oVALID ? 1'b0 : oOVERRUN;
      end else if (accept) begin
        oOVERRUN <= 1'b1;
      end else if (iREAD && oVALID) begin
        oVALID <= 1'b0;
        oOVERRUN <= 1'b0;
      end
    end
endmodule
